// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FPU datapath blocks (fmul/fadd/fdiv).
package fp_pkg;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   localparam int FLG_INVALID   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_INEXACT   = 0;

   function automatic int fp_bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // Canonical quiet NaN right-aligned in 64 bits; callers keep the low 1+EW+MW bits.
   function automatic logic [63:0] fp_qnan(input int ew, input int mw);
      logic [63:0] v;
      v = ((64'd1 << ew) - 64'd1) << mw;
      v = v | (64'd1 << (mw - 1));
      return v;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final FP stage: round-to-nearest-even, carry renormalisation, range check, pack and flags.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic                 sign,
   input  logic signed [EW+1:0] expo,
   input  logic [MW:0]          mant,
   input  logic                 guard,
   input  logic                 round,
   input  logic                 sticky,
   output logic [EW+MW:0]       y,
   output logic [3:0]           flags
);

   localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'((1 << EW) - 1);
   localparam logic signed [EW+1:0] ONE     = (EW+2)'(1);

   logic                 round_up;
   logic [MW+1:0]        mant_r;
   logic signed [EW+1:0] exp_r;
   logic [MW-1:0]        frac;

   always_comb begin
      round_up = guard & (round | sticky | mant[0]);
      mant_r   = {1'b0, mant} + {{(MW+1){1'b0}}, round_up};
      exp_r    = expo;
      frac     = mant_r[MW-1:0];
      y        = '0;
      flags    = '0;
      if (mant_r[MW+1]) begin
         exp_r = expo + ONE;
         frac  = mant_r[MW:1];
      end
      if (exp_r >= EXP_MAX) begin
         y                    = {sign, {EW{1'b1}}, {MW{1'b0}}};
         flags[FLG_OVERFLOW]  = 1'b1;
         flags[FLG_INEXACT]   = 1'b1;
      end else if (exp_r[EW+1] || exp_r == '0) begin
         y                    = {sign, {(EW+MW){1'b0}}};
         flags[FLG_UNDERFLOW] = 1'b1;
         flags[FLG_INEXACT]   = 1'b1;
      end else begin
         y                    = {sign, exp_r[EW-1:0], frac};
         flags[FLG_INEXACT]   = guard | round | sticky;
      end
   end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined FP multiplier with RNE, special values, flags and valid/ready flow control.
module fmul_pipe
   import fp_pkg::*;
#(
   parameter int EW    = 8,
   parameter int MW    = 23,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EW+MW:0]   x1,
   input  logic [EW+MW:0]   x2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EW+MW:0]   y,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_flags
);

   localparam int W  = 1 + EW + MW;
   localparam int MB = MW + 1;
   localparam int LO = MB / 2;
   localparam int HI = MB - LO;
   localparam int PW = 2 * MB;
   localparam logic signed [EW+1:0] BIAS_S = (EW+2)'(fp_bias(EW));
   localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EW, MW));

   function automatic fp_class_e classify(input logic [EW-1:0] e, input logic [MW-1:0] f);
      if (e == '0) return CLS_ZERO;
      if (e != '1) return CLS_NORM;
      if (f == '0) return CLS_INF;
      return f[MW-1] ? CLS_QNAN : CLS_SNAN;
   endfunction

   logic en;
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   fp_class_e      c1, c2;
   logic           sgn, sp;
   logic [W-1:0]   sp_y;
   logic [3:0]     sp_flags;
   logic [MB-1:0]  m1, m2;

   // Special-value resolution happens up front; its result rides the pipe and overrides S3.
   always_comb begin
      c1       = classify(x1[W-2 -: EW], x1[MW-1:0]);
      c2       = classify(x2[W-2 -: EW], x2[MW-1:0]);
      sgn      = x1[W-1] ^ x2[W-1];
      m1       = {1'b1, x1[MW-1:0]};
      m2       = {1'b1, x2[MW-1:0]};
      sp       = 1'b1;
      sp_y     = '0;
      sp_flags = '0;
      if (c1 == CLS_QNAN || c1 == CLS_SNAN || c2 == CLS_QNAN || c2 == CLS_SNAN) begin
         sp_y                  = QNAN;
         sp_flags[FLG_INVALID] = (c1 == CLS_SNAN) || (c2 == CLS_SNAN);
      end else if ((c1 == CLS_INF && c2 == CLS_ZERO) || (c1 == CLS_ZERO && c2 == CLS_INF)) begin
         sp_y                  = QNAN;
         sp_flags[FLG_INVALID] = 1'b1;
      end else if (c1 == CLS_INF || c2 == CLS_INF) begin
         sp_y = {sgn, {EW{1'b1}}, {MW{1'b0}}};
      end else if (c1 == CLS_ZERO || c2 == CLS_ZERO) begin
         sp_y = {sgn, {(W-1){1'b0}}};
      end else begin
         sp = 1'b0;
      end
   end

   logic                 v1, v2;
   logic [TAG_W-1:0]     tag1, tag2;
   logic                 sgn1, sgn2, sp1, sp2;
   logic [W-1:0]         sp_y1, sp_y2;
   logic [3:0]           sp_flags1, sp_flags2;
   logic signed [EW+1:0] exp1, exp2;
   logic [2*HI-1:0]      pp_hh;
   logic [HI+LO-1:0]     pp_hl, pp_lh;
   logic [2*LO-1:0]      pp_ll;
   logic [MB-1:0]        mant2;
   logic                 g2, r2, st2;
   logic [PW-1:0]        prod, nrm;

   always_comb begin
      prod = ({{(2*LO){1'b0}}, pp_hh} << (2*LO))
           + ({{MB{1'b0}}, pp_hl} << LO)
           + ({{MB{1'b0}}, pp_lh} << LO)
           + {{(2*HI){1'b0}}, pp_ll};
      nrm  = prod[PW-1] ? prod : (prod << 1);
   end

   always_ff @(posedge clk) begin
      if (en) begin
         tag1      <= in_tag;
         sgn1      <= sgn;
         sp1       <= sp;
         sp_y1     <= sp_y;
         sp_flags1 <= sp_flags;
         exp1      <= $signed({2'b00, x1[W-2 -: EW]}) + $signed({2'b00, x2[W-2 -: EW]}) - BIAS_S;
         pp_hh     <= {{HI{1'b0}}, m1[MB-1:LO]} * {{HI{1'b0}}, m2[MB-1:LO]};
         pp_hl     <= {{LO{1'b0}}, m1[MB-1:LO]} * {{HI{1'b0}}, m2[LO-1:0]};
         pp_lh     <= {{HI{1'b0}}, m1[LO-1:0]} * {{LO{1'b0}}, m2[MB-1:LO]};
         pp_ll     <= {{LO{1'b0}}, m1[LO-1:0]} * {{LO{1'b0}}, m2[LO-1:0]};

         tag2      <= tag1;
         sgn2      <= sgn1;
         sp2       <= sp1;
         sp_y2     <= sp_y1;
         sp_flags2 <= sp_flags1;
         exp2      <= exp1 + $signed({{(EW+1){1'b0}}, prod[PW-1]});
         mant2     <= nrm[PW-1 -: MB];
         g2        <= nrm[MW];
         r2        <= nrm[MW-1];
         st2       <= |nrm[MW-2:0];
      end
   end

   logic [W-1:0] rp_y;
   logic [3:0]   rp_flags;

   fp_round_pack #(.EW(EW), .MW(MW)) u_round_pack (
      .sign   (sgn2),
      .expo   (exp2),
      .mant   (mant2),
      .guard  (g2),
      .round  (r2),
      .sticky (st2),
      .y      (rp_y),
      .flags  (rp_flags)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
         out_tag   <= '0;
         out_flags <= '0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (v2) begin
            y         <= sp2 ? sp_y2 : rp_y;
            out_flags <= sp2 ? sp_flags2 : rp_flags;
            out_tag   <= tag2;
         end
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: directed corner cases, stall/reset scenarios and randomized traffic vs. an arithmetic model.
`timescale 1ns/1ps
module tb_fmul_pipe;

   localparam int EW = 8, MW = 23, TAG_W = 4, W = 32;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             in_valid = 1'b0, out_ready = 1'b0;
   logic             in_ready, out_valid;
   logic [W-1:0]     x1 = '0, x2 = '0, y;
   logic [TAG_W-1:0] in_tag = '0, out_tag;
   logic [3:0]       out_flags;

   int          n_tests = 0, n_fail = 0, n_recv = 0;
   logic [39:0] sb[$];
   logic        use_dir = 1'b0;
   logic [35:0] dir_exp = '0;
   logic        fired = 1'b0, accepted = 1'b0, held = 1'b0;
   logic [39:0] held_val = '0;

   localparam logic [31:0] D_A [8] = '{32'h3FC00000, 32'h3F800001, 32'h3F800000, 32'h7F7FFFFF,
                                       32'h00800000, 32'h7F800000, 32'h7F800001, 32'h80000000};
   localparam logic [31:0] D_B [8] = '{32'h40000000, 32'h3F800001, 32'hBF800000, 32'h40000000,
                                       32'h00800000, 32'h00000000, 32'h3F800000, 32'h40400000};
   localparam logic [31:0] D_Y [8] = '{32'h40400000, 32'h3F800002, 32'hBF800000, 32'h7F800000,
                                       32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
   localparam logic [3:0]  D_F [8] = '{4'h0, 4'h1, 4'h0, 4'h5, 4'h3, 4'h8, 4'h8, 4'h0};

   fmul_pipe #(.EW(EW), .MW(MW), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x1        (x1),
      .x2        (x2),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .out_tag   (out_tag),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product, then quotient/remainder rounding to 24 significant bits.
   function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int          ea, eb, e, sh;
      logic        s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, inx;
      logic [63:0] p, q, rem, half;
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      s      = a[31] ^ b[31];
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_snan = a_nan && !a[22];
      b_snan = b_nan && !b[22];
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan) return {a_snan || b_snan, 3'b000, 32'h7FC00000};
      if ((a_inf && b_zero) || (a_zero && b_inf)) return {4'b1000, 32'h7FC00000};
      if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {4'b0000, s, 31'd0};
      p  = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      e  = ea + eb - 127;
      sh = 23;
      if (p >= 64'h8000_0000_0000) begin
         sh = 24;
         e++;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == 64'h100_0000) begin
         q = q >> 1;
         e++;
      end
      inx = (rem != 0);
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0) return {4'b0011, s, 31'd0};
      return {3'b000, inx, s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 11))
         0: r[30:23] = 8'd0;
         1: begin
            r[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 1) r[22:0] = '0;
         end
         2: r[30:23] = 8'($urandom_range(1, 40));
         3: r[30:23] = 8'($urandom_range(200, 254));
         4: begin
            r[30:23] = 8'($urandom_range(110, 140));
            r[22:0]  = '1;
         end
         default: r[30:23] = 8'($urandom_range(90, 164));
      endcase
      return r;
   endfunction

   // Called at a negedge after inputs are set; samples at +1 and returns at the next negedge.
   task automatic tick();
      logic [39:0] e;
      #1;
      check_eq("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (held) begin
         check_eq("hold_valid", 64'(out_valid), 64'd1);
         check_eq("hold_out", 64'({out_tag, out_flags, y}), 64'(held_val));
      end
      held     = out_valid && !out_ready;
      held_val = {out_tag, out_flags, y};
      fired    = out_valid && out_ready;
      if (fired) begin
         if (sb.size() == 0) begin
            check_eq("spurious", 64'(out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check_eq("y", 64'(y), 64'(e[31:0]));
            check_eq("flags", 64'(out_flags), 64'(e[35:32]));
            check_eq("tag", 64'(out_tag), 64'(e[39:36]));
            n_recv++;
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) sb.push_back({in_tag, use_dir ? dir_exp : ref_mul(x1, x2)});
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n         = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      check_eq("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic lat_op(input int i, input logic [3:0] t);
      int n;
      x1        = D_A[i];
      x2        = D_B[i];
      in_tag    = t;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      use_dir   = 1'b1;
      dir_exp   = {D_F[i], D_Y[i]};
      tick();
      use_dir  = 1'b0;
      in_valid = 1'b0;
      n        = 0;
      fired    = 1'b0;
      while (!fired && n < 20) begin
         tick();
         n++;
      end
      check_eq("latency", 64'(n), 64'd3);
   endtask

   initial begin
      int idx;
      #2;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_y", 64'(y), 64'd0);
      check_eq("rst_tag", 64'(out_tag), 64'd0);
      check_eq("rst_flags", 64'(out_flags), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      lat_op(0, 4'd9);
      for (int i = 1; i < 8; i++) begin
         x1        = D_A[i];
         x2        = D_B[i];
         in_tag    = 4'(i);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         use_dir   = 1'b1;
         dir_exp   = {D_F[i], D_Y[i]};
         tick();
      end
      use_dir = 1'b0;
      drain();

      idx    = 0;
      n_recv = 0;
      x1     = rand_op();
      x2     = rand_op();
      in_tag = '0;
      for (int c = 0; c < 60 && n_recv < 8; c++) begin
         in_valid  = (idx < 8);
         out_ready = !(c >= 4 && c <= 6);
         tick();
         if (accepted) begin
            idx++;
            x1     = rand_op();
            x2     = rand_op();
            in_tag = 4'(idx);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_eq("stall_recv", 64'(n_recv), 64'd8);
      check_eq("stall_sb_empty", 64'(sb.size()), 64'd0);

      for (int i = 0; i < 3; i++) begin
         x1        = rand_op();
         x2        = rand_op();
         in_tag    = 4'(10 + i);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
      check_eq("midrst_y", 64'(y), 64'd0);
      check_eq("midrst_tag", 64'(out_tag), 64'd0);
      check_eq("midrst_flags", 64'(out_flags), 64'd0);
      sb.delete();
      held = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) tick();
      lat_op(2, 4'd5);

      for (int c = 0; c < 600; c++) begin
         x1        = rand_op();
         x2        = rand_op();
         in_tag    = 4'($urandom);
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
